// File: rtl/free_list.sv
// Physical-register free list: circular buffer of free tags with two-wide pop
// (dispatch) and push (retire), plus head recovery on branch mispredict.
module free_list #(
    parameter int NUM_PHYS = 64,
    parameter int NUM_FREE = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [1:0]                            haz_nDispatched,
    input  logic [1:0]                            rob_nRetired,
    input  logic [1:0][$clog2(NUM_PHYS)-1:0]      rob_retireTagOld,
    input  logic                                  br_fub_pred_wrong,
    input  logic [$clog2(NUM_FREE):0]             bs_recov_fl_head,
    output logic [1:0][$clog2(NUM_PHYS)-1:0]      fl_freeRegs,
    output logic [$clog2(NUM_FREE):0]             fl_availableRegs,
    output logic [$clog2(NUM_FREE):0]             fl_head,
    output logic                                  fl_err
);

    localparam int PR_W  = $clog2(NUM_PHYS);
    localparam int IDX_W = $clog2(NUM_FREE);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(NUM_FREE);

    logic [PR_W-1:0]  r_buf [0:NUM_FREE-1];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic             r_err;

    logic [PTR_W-1:0] w_count;
    logic [IDX_W-1:0] w_hidx0;
    logic [IDX_W-1:0] w_hidx1;
    logic [IDX_W-1:0] w_tidx0;
    logic [IDX_W-1:0] w_tidx1;
    logic [1:0]       w_nd;
    logic [1:0]       w_nr;
    logic             w_bad_code;
    logic             w_under;
    logic [1:0]       w_pops;
    logic [PTR_W:0]   w_after;
    logic             w_over;
    logic [1:0]       w_push;
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [PTR_W-1:0] w_recov_cnt;
    logic             w_recov_bad;
    logic             w_err_set;

    assign w_count = r_tail - r_head;
    assign w_hidx0 = r_head[IDX_W-1:0];
    assign w_hidx1 = w_hidx0 + IDX_W'(1);
    assign w_tidx0 = r_tail[IDX_W-1:0];
    assign w_tidx1 = w_tidx0 + IDX_W'(1);

    // An encoding of 3 is illegal for both widths; it is squashed to 0 and flagged.
    assign w_nd       = (haz_nDispatched == 2'd3) ? 2'd0 : haz_nDispatched;
    assign w_nr       = (rob_nRetired == 2'd3)    ? 2'd0 : rob_nRetired;
    assign w_bad_code = (haz_nDispatched == 2'd3) || (rob_nRetired == 2'd3);

    assign w_under = !br_fub_pred_wrong && (PTR_W'(w_nd) > w_count);
    assign w_pops  = (br_fub_pred_wrong || w_under) ? 2'd0 : w_nd;

    // Pops never exceed the current count here, so the difference cannot go negative.
    assign w_after = {1'b0, w_count} + (PTR_W+1)'(w_nr) - (PTR_W+1)'(w_pops);
    assign w_over  = w_after > FULL_CNT;
    assign w_push  = w_over ? 2'd0 : w_nr;

    assign w_tail_nxt  = r_tail + PTR_W'(w_push);
    assign w_head_nxt  = br_fub_pred_wrong ? bs_recov_fl_head : (r_head + PTR_W'(w_pops));
    assign w_recov_cnt = w_tail_nxt - bs_recov_fl_head;
    assign w_recov_bad = br_fub_pred_wrong && ({1'b0, w_recov_cnt} > FULL_CNT);
    assign w_err_set   = w_bad_code || w_under || w_over || w_recov_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= PTR_W'(NUM_FREE);
            r_err  <= 1'b0;
        end else begin
            r_head <= w_head_nxt;
            r_tail <= w_tail_nxt;
            if (w_err_set) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_FREE; i++) begin
                r_buf[i] <= PR_W'(NUM_PHYS - NUM_FREE + i);
            end
        end else begin
            if (w_push != 2'd0) begin
                r_buf[w_tidx0] <= rob_retireTagOld[0];
            end
            if (w_push == 2'd2) begin
                r_buf[w_tidx1] <= rob_retireTagOld[1];
            end
        end
    end

    assign fl_freeRegs[0]   = r_buf[w_hidx0];
    assign fl_freeRegs[1]   = r_buf[w_hidx1];
    assign fl_availableRegs = w_count;
    assign fl_head          = r_head;
    assign fl_err           = r_err;

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: directed vector table, multi-cycle corner
// sequences, and seeded random traffic against an array-based reference model.
module tb_free_list;

    logic            clk;
    logic            reset;
    logic [1:0]      haz_nDispatched;
    logic [1:0]      rob_nRetired;
    logic [1:0][5:0] rob_retireTagOld;
    logic            br_fub_pred_wrong;
    logic [5:0]      bs_recov_fl_head;
    logic [1:0][5:0] fl_freeRegs;
    logic [5:0]      fl_availableRegs;
    logic [5:0]      fl_head;
    logic            fl_err;

    free_list #(.NUM_PHYS(64), .NUM_FREE(32)) dut (
        .clk               (clk),
        .reset             (reset),
        .haz_nDispatched   (haz_nDispatched),
        .rob_nRetired      (rob_nRetired),
        .rob_retireTagOld  (rob_retireTagOld),
        .br_fub_pred_wrong (br_fub_pred_wrong),
        .bs_recov_fl_head  (bs_recov_fl_head),
        .fl_freeRegs       (fl_freeRegs),
        .fl_availableRegs  (fl_availableRegs),
        .fl_head           (fl_head),
        .fl_err            (fl_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: pointers as plain integers modulo 64, entries in an array.
    int         mh, mt;
    logic [5:0] mb [32];
    bit         me;

    typedef struct {
        logic [1:0] nd;
        logic [1:0] nr;
        logic [5:0] t0;
        logic [5:0] t1;
        logic       mp;
        logic [5:0] rc;
        int         eh;
        int         ec;
        int         ef0;
        int         ef1;
        int         ee;
    } vec_t;

    vec_t tbl [5];

    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input int nd, input int nr, input int t0, input int t1,
                         input int mp, input int rc);
        haz_nDispatched     = 2'(nd);
        rob_nRetired        = 2'(nr);
        rob_retireTagOld[0] = 6'(t0);
        rob_retireTagOld[1] = 6'(t1);
        br_fub_pred_wrong   = 1'(mp);
        bs_recov_fl_head    = 6'(rc);
    endtask

    task automatic step(input int nd, input int nr, input int t0, input int t1,
                        input int mp, input int rc);
        drive(nd, nr, t0, t1, mp, rc);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic model_reset();
        mh = 0;
        mt = 32;
        me = 1'b0;
        for (int i = 0; i < 32; i++) mb[i] = 6'(32 + i);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_state(input string nm, input int eh, input int ec,
                               input int ef0, input int ef1, input int ee);
        check({nm, ".head"},  int'(fl_head), eh);
        check({nm, ".count"}, int'(fl_availableRegs), ec);
        check({nm, ".free0"}, int'(fl_freeRegs[0]), ef0);
        check({nm, ".free1"}, int'(fl_freeRegs[1]), ef1);
        check({nm, ".err"},   int'(fl_err), ee);
    endtask

    task automatic model_step(input int nd_in, input int nr_in, input int t0, input int t1,
                              input int mp, input int rc);
        int cnt, nd, nr, pops;
        cnt = (mt - mh) & 63;
        nd  = nd_in;
        nr  = nr_in;
        if (nd == 3) begin nd = 0; me = 1'b1; end
        if (nr == 3) begin nr = 0; me = 1'b1; end
        pops = 0;
        if (mp == 0) begin
            if (nd > cnt) me = 1'b1;
            else pops = nd;
        end
        if (cnt + nr - pops > 32) begin
            me = 1'b1;
        end else begin
            if (nr >= 1) mb[mt % 32] = 6'(t0);
            if (nr == 2) mb[(mt + 1) % 32] = 6'(t1);
            mt = (mt + nr) & 63;
        end
        if (mp != 0) begin
            mh = rc & 63;
            if (((mt - mh) & 63) > 32) me = 1'b1;
        end else begin
            mh = (mh + pops) & 63;
        end
    endtask

    task automatic check_model();
        int bad_idx;
        check_state("rand", mh, (mt - mh) & 63, int'(mb[mh % 32]), int'(mb[(mh + 1) % 32]), int'(me));
        check("rand.tail", int'(dut.r_tail), mt);
        bad_idx = -1;
        for (int i = 0; i < 32; i++) begin
            if (bad_idx < 0 && dut.r_buf[i] != mb[i]) bad_idx = i;
        end
        if (bad_idx < 0) check("rand.entries", 0, 0 * n_cmp);
        else check("rand.entries", int'(dut.r_buf[bad_idx]), int'(mb[bad_idx]));
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);

        //              nd nr  t0  t1 mp rc  head cnt f0  f1  err
        tbl[0] = '{2'd2, 2'd0, 6'd0,  6'd0,  1'b0, 6'd0, 2, 30, 34, 35, 0};
        tbl[1] = '{2'd1, 2'd1, 6'd9,  6'd0,  1'b0, 6'd0, 3, 30, 35, 36, 0};
        tbl[2] = '{2'd0, 2'd0, 6'd0,  6'd0,  1'b1, 6'd1, 1, 32, 33, 34, 0};
        tbl[3] = '{2'd2, 2'd2, 6'd20, 6'd21, 1'b0, 6'd0, 3, 32, 35, 36, 0};
        tbl[4] = '{2'd0, 2'd1, 6'd11, 6'd0,  1'b0, 6'd0, 3, 32, 35, 36, 1};

        @(negedge clk);
        do_reset();
        check_state("reset", 0, 32, 32, 33, 0);

        for (int v = 0; v < 5; v++) begin
            step(tbl[v].nd, tbl[v].nr, tbl[v].t0, tbl[v].t1, tbl[v].mp, tbl[v].rc);
            check_state($sformatf("vec%0d", v), tbl[v].eh, tbl[v].ec, tbl[v].ef0, tbl[v].ef1, tbl[v].ee);
        end
        check("vec.buf0", int'(dut.r_buf[0]), 9);

        // Drain fully, then refill two tags.
        do_reset();
        for (int i = 0; i < 16; i++) step(2, 0, 0, 0, 0, 0);
        check("drain.count", int'(fl_availableRegs), 0);
        check("drain.head", int'(fl_head), 32);
        step(0, 2, 5, 7, 0, 0);
        check_state("refill", 32, 2, 5, 7, 0);

        // Head at index 31 with a full list; dispatch 2 wraps the head.
        do_reset();
        for (int i = 0; i < 31; i++) step(1, 1, i + 1, 0, 0, 0);
        check_state("wrap.pre", 31, 32, 63, 1, 0);
        step(2, 0, 0, 0, 0, 0);
        check_state("wrap.post", 33, 30, 2, 3, 0);

        // Mispredict with a simultaneous retire: recovered count exceeds 32.
        do_reset();
        for (int i = 0; i < 4; i++) step(2, 2, 50 + i, 60, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        check("mp.pre.head", int'(fl_head), 10);
        check("mp.pre.count", int'(fl_availableRegs), 30);
        step(2, 1, 44, 0, 1, 6);
        check("mp.head", int'(fl_head), 6);
        check("mp.tail", int'(dut.r_tail), 41);
        check("mp.count", int'(fl_availableRegs), 35);
        check("mp.err", int'(fl_err), 1);

        // Underflow holds head; error is sticky until reset.
        do_reset();
        for (int i = 0; i < 15; i++) step(2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check("uf.pre.count", int'(fl_availableRegs), 1);
        step(2, 0, 0, 0, 0, 0);
        check("uf.head", int'(fl_head), 31);
        check("uf.count", int'(fl_availableRegs), 1);
        check("uf.err", int'(fl_err), 1);
        for (int i = 0; i < 3; i++) step(0, 1, 3, 0, 0, 0);
        check("uf.sticky", int'(fl_err), 1);
        do_reset();
        check("uf.cleared", int'(fl_err), 0);

        // Illegal encodings of 3 are squashed to zero and flagged.
        step(3, 0, 0, 0, 0, 0);
        check_state("nd3", 0, 32, 32, 33, 1);
        do_reset();
        step(2, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        step(0, 3, 1, 2, 0, 0);
        check_state("nr3", 4, 28, 36, 37, 1);

        // Asynchronous reset overrides pending pushes and pops.
        do_reset();
        step(2, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        drive(2, 2, 12, 13, 0, 0);
        #2 reset = 1'b1;
        #1 check_state("arst.async", 0, 32, 32, 33, 0);
        @(posedge clk);
        @(negedge clk);
        check_state("arst.held", 0, 32, 32, 33, 0);
        check("arst.tail", int'(dut.r_tail), 32);
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Seeded random legal traffic against the reference model.
        for (int seed = 0; seed < 6; seed++) begin
            void'($urandom(seed));
            do_reset();
            for (int c = 0; c < 850; c++) begin
                int cnt, nd, nr, mp, rc, t0, t1, maxd, maxr;
                cnt  = (mt - mh) & 63;
                maxd = (cnt < 2) ? cnt : 2;
                maxr = (32 - cnt < 2) ? (32 - cnt) : 2;
                nd   = $urandom_range(maxd, 0);
                nr   = $urandom_range(maxr, 0);
                t0   = $urandom_range(63, 0);
                t1   = $urandom_range(63, 0);
                mp   = ($urandom_range(15, 0) == 0) ? 1 : 0;
                rc   = 0;
                if (mp != 0) rc = (mh - int'($urandom_range(32 - cnt - nr, 0))) & 63;
                drive(nd, nr, t0, t1, mp, rc);
                @(posedge clk);
                model_step(nd, nr, t0, t1, mp, rc);
                @(negedge clk);
                check_model();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
